gsm_mac_sequencer: RTL and testbench
====================================

Name: gsm_mac_sequencer

Overview:
- Time-multiplexed controller for the real-only gate x state multiply: out = gate * state over a 2^N x 2^N gate and a 2^N state.
- Drives one shared signed multiply-accumulate. Walks row/col addresses into the gate and state register files and writes each finished row to the output state buffer.
- Manages a two-entry state ping-pong so chained gates reuse the previous output without a bulk copy.
- Sits between the load/send FSM (start/chain/done) and the gate/state storage.

Parameters:
- N, 3, number of qubits; vector length MAX = 2^N.
- FRAC, 14, fraction bits of the signed Q(15-FRAC).FRAC data format (1.0 = 0x4000).
- ACC_W, 32+N, accumulator width; holds MAX full 32-bit products without overflow.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a multiply; sampled only in IDLE.
- chain  in  1  sampled with start; 1 = use the previous output buffer as input.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last row write.
- gate_row  out  N  gate read row address.
- gate_col  out  N  gate read column address; also drives the state read address.
- state_sel  out  1  selects the input state buffer; the output buffer is ~state_sel.
- gate_data  in  16  gate element, valid 1 cycle after its address.
- state_data  in  16  state element from the selected buffer, valid 1 cycle after its address.
- out_addr  out  N  output-state write index.
- out_data  out  16  output-state write value.
- out_we  out  1  output-state write strobe.
- sat  out  1  sticky saturation flag, cleared on accepted start.

Behaviour:
- Reset values: state IDLE, busy=0, done=0, out_we=0, gate_row=0, gate_col=0, out_addr=0, out_data=0, state_sel=0, sat=0, accumulator=0.
- IDLE:
  - start=1 -> MAC, busy=1, row=0, col=0, acc=0, sat=0.
  - On the same edge: chain=0 -> state_sel<=0; chain=1 -> state_sel<=~state_sel.
- MAC (MAX cycles per row):
  - Presents gate_row=row and gate_col=col, with col counting 0..MAX-1.
  - From the second MAC cycle, adds sign-extended gate_data*state_data (32-bit signed product) to acc.
  - After col=MAX-1 -> DRAIN.
- DRAIN (1 cycle): accumulates the final product -> WRITE.
- WRITE (1 cycle):
  - out_we=1, out_addr=row, out_data=sat16(acc >>> FRAC) (arithmetic shift, truncating).
  - acc<=0, col<=0.
  - row==MAX-1 -> DONE; otherwise row+1 -> MAC.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
- Latency: start accepted on cycle 0; row r WRITE on cycle (r+1)*(MAX+2); done on cycle MAX*(MAX+2)+1. For N=3: writes on cycles 10,20..80; done on cycle 81.
- out_we is high only in WRITE. out_data holds its last value otherwise.
- start while not in IDLE is ignored; it is neither queued nor restarts the run. chain is ignored without start.
- state_sel is stable for the entire run and changes only on an accepted start.
- reset in any state returns to IDLE with reset values on the next edge. The partial row is not written.

Optional Feature:
- Macro GSM_MAC_SAT_EN.
- Defined: sat16 clamps to 0x7FFF / 0x8000. sat is set (sticky) whenever a clamp occurs in WRITE.
- Undefined: sat16 keeps the low 16 bits (two's-complement wrap); sat is tied 0.

Test Plan:
- Identity gate (diagonal 0x4000, else 0), state_sel=0 buffer [0x4000,0,...,0], start, chain=0 (N=3):
  - writes on cycles 10..80 with addresses 0..7, data [0x4000,0,...,0].
  - done on cycle 81 only; busy high cycles 1..81 exclusive of done cycle; state_sel=0.
- Gate all 0x2000 (0.5), state [0x0800 x8]: each out_data = 8*0.5*0.125 = 0x2000, sat=0.
- Chaining: X-type permutation gate (row r -> col r^1), state [0x4000,0x1000,0,...].
  - Run 1 (chain=0) output [0x1000,0x4000,0,...].
  - Start chain=1: state_sel=1; output is the original vector.
- Overflow: gate all 0x4000, state all 0x4000 (sum 8.0):
  - With GSM_MAC_SAT_EN, all out_data=0x7FFF, sat=1.
  - Without it, out_data=0x0000, sat=0.
  - Gate all 0xC000 with the same state: 0x8000 (sat=1) / 0x0000 (sat=0).
- Start pulsed on cycle 30 of a run -> no effect, done still on cycle 81. Reset asserted on cycle 35 -> IDLE on the next edge, no further out_we, state_sel=0, sat=0.

Source files
------------

// File: rtl/gsm_mac_sequencer.sv
// gsm_mac_sequencer
// Time-multiplexed controller for the real-valued gate x state product
// out = gate * state, over a 2^N x 2^N gate and a 2^N state vector.
// It walks one shared signed multiply-accumulate across each gate row.
// It also streams the finished rows into the output state buffer.
// A two-entry state ping-pong (state_sel) lets chained gates consume the
// previous output directly.
//
// Build option: define GSM_MAC_SAT_EN to clamp written samples to
// 0x7FFF / 0x8000 and raise the sticky sat flag. Without it, samples wrap
// (two's complement) and sat stays 0.
module gsm_mac_sequencer #(
  parameter int N     = 3,
  parameter int FRAC  = 14,
  parameter int ACC_W = 32 + N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         chain,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] gate_row,
  output logic [N-1:0] gate_col,
  output logic         state_sel,
  input  logic [15:0]  gate_data,
  input  logic [15:0]  state_data,
  output logic [N-1:0] out_addr,
  output logic [15:0]  out_data,
  output logic         out_we,
  output logic         sat
);

  localparam int MAX = 1 << N;
  localparam logic [N-1:0] LAST = N'(MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       row_q, row_d;
  logic [N-1:0]       col_q, col_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [N-1:0]       out_addr_q, out_addr_d;
  logic [15:0]        out_data_q, out_data_d;
  logic               sel_q, sel_d;
  logic               sat_q, sat_d;

  logic signed [31:0] prod;
  logic [ACC_W-1:0]   acc_sum;
  logic [15:0]        sat16_val;
  logic               clamp;

  // Product of the element pair whose address was presented last cycle
  assign prod    = $signed(gate_data) * $signed(state_data);
  assign acc_sum = acc_q + {{(ACC_W-32){prod[31]}}, prod};

`ifdef GSM_MAC_SAT_EN
  logic signed [ACC_W-1:0] shifted;
  logic                    ovf;

  // Scale back to Q format and clamp anything outside the 16-bit range
  always_comb begin
    shifted   = $signed(acc_sum) >>> FRAC;
    ovf       = ~((&shifted[ACC_W-1:15]) | ~(|shifted[ACC_W-1:15]));
    clamp     = ovf;
    sat16_val = ovf ? (shifted[ACC_W-1] ? 16'h8000 : 16'h7FFF) : shifted[15:0];
  end
`else
  // Scale back to Q format keeping only the low 16 bits (wrap)
  always_comb begin
    clamp     = 1'b0;
    sat16_val = acc_sum[FRAC+15:FRAC];
  end
`endif

  // Next-state and datapath control for the row/column walk
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    acc_d      = acc_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    sel_d      = sel_q;
    sat_d      = sat_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MAC;
          row_d   = '0;
          col_d   = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
          sel_d   = chain ? ~sel_q : 1'b0;
        end
      end

      S_MAC: begin
        // Column 0 data is not back yet on the first cycle of a row
        if (col_q != '0) acc_d = acc_sum;
        if (col_q == LAST) state_d = S_DRAIN;
        else               col_d   = col_q + 1'b1;
      end

      S_DRAIN: begin
        // Fold in the last product and stage the row result for WRITE
        acc_d      = acc_sum;
        out_addr_d = row_q;
        out_data_d = sat16_val;
        if (clamp) sat_d = 1'b1;
        state_d    = S_WRITE;
      end

      S_WRITE: begin
        acc_d = '0;
        col_d = '0;
        if (row_q == LAST) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = S_MAC;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      acc_q      <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      sel_q      <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      acc_q      <= acc_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      sel_q      <= sel_d;
      sat_q      <= sat_d;
    end
  end

  assign busy      = (state_q == S_MAC) || (state_q == S_DRAIN) || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign out_we    = (state_q == S_WRITE);
  assign gate_row  = row_q;
  assign gate_col  = col_q;
  assign state_sel = sel_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_gsm_mac_sequencer.sv
// Testbench for gsm_mac_sequencer (N=3, FRAC=14).
// Provides gate and ping-pong state storage with one-cycle read latency.
// Every run pushes its expected row writes and done cycle into queues.
// A negedge monitor pops and compares those whenever the DUT writes or
// signals done. Cycle numbers count from the start-acceptance cycle (0).
`timescale 1ns/1ps
module tb_gsm_mac_sequencer;

  localparam int N   = 3;
  localparam int MAX = 8;

`ifdef GSM_MAC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef logic [15:0] vec_t [MAX];

  typedef struct {
    int          cyc;
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         reset, start, chain;
  logic         busy, done, state_sel, out_we, sat;
  logic [N-1:0] gate_row, gate_col, out_addr;
  logic [15:0]  gate_data, state_data, out_data;

  wr_t wq[$];
  int  dq[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  edge_cnt = 0;
  int  t0       = 0;

  logic [15:0] gate_mem [MAX][MAX];
  logic [15:0] sbuf     [2][MAX];
  logic [15:0] ld_buf   [MAX];
  int          ld_sel   = 0;
  int          ld_req   = 0;
  int          ld_seen  = 0;

  always #5 clk = ~clk;

  gsm_mac_sequencer #(.N(N), .FRAC(14), .ACC_W(32 + N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .chain     (chain),
    .busy      (busy),
    .done      (done),
    .gate_row  (gate_row),
    .gate_col  (gate_col),
    .state_sel (state_sel),
    .gate_data (gate_data),
    .state_data(state_data),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_we    (out_we),
    .sat       (sat)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Storage model: registered reads, bench preloads, DUT write-back
  always @(posedge clk) begin
    gate_data  <= gate_mem[gate_row][gate_col];
    state_data <= sbuf[state_sel][gate_col];
    if (ld_req != ld_seen) begin
      for (int i = 0; i < MAX; i++) sbuf[ld_sel][i] <= ld_buf[i];
      ld_seen <= ld_req;
    end else if (out_we === 1'b1) begin
      sbuf[~state_sel][out_addr] <= out_data;
    end
  end

  // Monitor: compare every write and done pulse against the queues
  always @(negedge clk) begin
    int  rel;
    int  dc;
    wr_t e;
    rel = edge_cnt - t0;
    if (out_we === 1'b1) begin
      if (wq.size() == 0) begin
        check($sformatf("unexpected_write_cyc%0d", rel), 1, 0);
      end else begin
        e = wq.pop_front();
        check($sformatf("wr_row%0d_cycle", e.addr), rel, e.cyc);
        check($sformatf("wr_row%0d_addr", e.addr), {29'd0, out_addr}, {29'd0, e.addr});
        check($sformatf("wr_row%0d_data", e.addr), {16'd0, out_data}, {16'd0, e.data});
      end
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) begin
        check($sformatf("unexpected_done_cyc%0d", rel), 1, 0);
      end else begin
        dc = dq.pop_front();
        check("done_cycle", rel, dc);
        check("busy_low_at_done", {31'd0, busy}, 0);
      end
    end
  end

  task automatic gate_fill(input logic [15:0] v);
    for (int r = 0; r < MAX; r++)
      for (int c = 0; c < MAX; c++) gate_mem[r][c] = v;
  endtask

  // Single nonzero per row at column r ^ xmask (0 = identity, 1 = X-type swap)
  task automatic gate_perm(input logic [15:0] v, input int xmask);
    for (int r = 0; r < MAX; r++)
      for (int c = 0; c < MAX; c++) gate_mem[r][c] = (c == (r ^ xmask)) ? v : 16'h0000;
  endtask

  task automatic load_state(input int sel, input vec_t v);
    for (int i = 0; i < MAX; i++) ld_buf[i] = v[i];
    ld_sel = sel;
    ld_req++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},      {31'd0, busy},      0);
    check({tag, "_done"},      {31'd0, done},      0);
    check({tag, "_out_we"},    {31'd0, out_we},    0);
    check({tag, "_gate_row"},  {29'd0, gate_row},  0);
    check({tag, "_gate_col"},  {29'd0, gate_col},  0);
    check({tag, "_out_addr"},  {29'd0, out_addr},  0);
    check({tag, "_out_data"},  {16'd0, out_data},  0);
    check({tag, "_state_sel"}, {31'd0, state_sel}, 0);
    check({tag, "_sat"},       {31'd0, sat},       0);
  endtask

  // One run: nrows expected writes, optional stray start pulse and mid-run reset
  task automatic run(input string tag, input logic ch, input vec_t exp, input int nrows,
                     input logic exp_sel, input logic exp_sat,
                     input int pulse_cyc, input int rst_cyc);
    int  rel;
    bit  seen;
    wr_t e;
    for (int r = 0; r < nrows; r++) begin
      e.cyc  = (r + 1) * (MAX + 2);
      e.addr = 3'(r);
      e.data = exp[r];
      wq.push_back(e);
    end
    if (rst_cyc == 0) dq.push_back(MAX * (MAX + 2) + 1);
    @(negedge clk);
    start = 1'b1;
    chain = ch;
    @(posedge clk);
    #1;
    t0    = edge_cnt - 1;
    start = 1'b0;
    chain = 1'b0;
    @(negedge clk);
    check({tag, "_busy_cyc1"},  {31'd0, busy},      1);
    check({tag, "_sel_cyc1"},   {31'd0, state_sel}, {31'd0, exp_sel});
    check({tag, "_sat_clear"},  {31'd0, sat},       0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      rel   = edge_cnt - t0;
      start = 1'b0;
      chain = 1'b0;
      if (rel == pulse_cyc) begin
        start = 1'b1;
        chain = 1'b1;
      end
      if (rst_cyc != 0 && rel == rst_cyc) begin
        check({tag, "_sat_pre_reset"}, {31'd0, sat},       {31'd0, exp_sat});
        check({tag, "_sel_pre_reset"}, {31'd0, state_sel}, {31'd0, exp_sel});
        reset = 1'b1;
      end else if (rst_cyc != 0 && rel == rst_cyc + 1) begin
        reset = 1'b0;
        check_reset_values({tag, "_after_reset"});
        seen = 1'b1;
      end else if (rst_cyc == 0 && done === 1'b1) begin
        seen = 1'b1;
      end
    end
    check({tag, "_finished"}, {31'd0, seen}, 1);
    if (rst_cyc != 0) repeat (100) @(negedge clk);
    @(negedge clk);
    check({tag, "_writes_pending"}, wq.size(), 0);
    check({tag, "_done_pending"},   dq.size(), 0);
    if (rst_cyc == 0) begin
      check({tag, "_sel_end"},  {31'd0, state_sel}, {31'd0, exp_sel});
      check({tag, "_sat_end"},  {31'd0, sat},       {31'd0, exp_sat});
      check({tag, "_busy_end"}, {31'd0, busy},      0);
    end
    wq.delete();
    dq.delete();
  endtask

  initial begin
    vec_t v;
    vec_t ovp;
    vec_t ovn;
    reset = 1'b1;
    start = 1'b0;
    chain = 1'b0;
    gate_fill(16'h0000);
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    // Identity gate on a basis vector
    gate_perm(16'h4000, 0);
    load_state(0, '{16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});
    run("identity", 1'b0, '{16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
        MAX, 1'b0, 1'b0, 0, 0);

    // Uniform 0.5 gate on uniform 0.125 state: 8 * 0.0625 = 0.5
    gate_fill(16'h2000);
    load_state(0, '{default: 16'h0800});
    run("half", 1'b0, '{default: 16'h2000}, MAX, 1'b0, 1'b0, 0, 0);

    // X-type permutation, then chained back through the ping-pong
    gate_perm(16'h4000, 1);
    load_state(0, '{16'h4000, 16'h1000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});
    run("xgate_run1", 1'b0, '{16'h1000, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
        MAX, 1'b0, 1'b0, 0, 0);
    run("xgate_chain", 1'b1, '{16'h4000, 16'h1000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
        MAX, 1'b1, 1'b0, 0, 0);

    // Row sums of +8.0 and -8.0 overflow the 16-bit output
    for (int i = 0; i < MAX; i++) begin
      ovp[i] = SAT_EN ? 16'h7FFF : 16'h0000;
      ovn[i] = SAT_EN ? 16'h8000 : 16'h0000;
    end
    gate_fill(16'h4000);
    load_state(0, '{default: 16'h4000});
    run("ovf_pos", 1'b0, ovp, MAX, 1'b0, SAT_EN, 30, 0);
    gate_fill(16'hC000);
    load_state(0, '{default: 16'h4000});
    run("ovf_neg", 1'b0, ovn, MAX, 1'b0, SAT_EN, 0, 0);

    // Reset mid-run on cycle 35: rows 0..2 written, nothing after
    gate_fill(16'h4000);
    load_state(1, '{default: 16'h4000});
    v = ovp;
    run("mid_reset", 1'b1, v, 3, 1'b1, SAT_EN, 0, 35);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
